// File: rtl/w_load_sequencer_pkg.sv
// Shared definitions for the W load sequencer: state encoding and default widths.
package w_load_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 5;  // W data / w_output width
  localparam int unsigned CNT_W_DEF = 4;  // load-count field width
  localparam int unsigned GAP_DEF   = 2;  // idle cycles after each load_w pulse

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/w_load_sequencer_if.sv
// Command / counter-side bus of the W load sequencer.
//   start, num_loads, init_w : command from the MCU control logic
//   w_output                 : feedback from the W counter
//   load_w, w_data           : load strobe and data towards the counter
//   busy, done, mismatch     : status back to the control logic
// master = control/counter side, slave = sequencer.
interface w_load_sequencer_if
  import w_load_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] num_loads;
  logic [WIDTH-1:0] init_w;
  logic [WIDTH-1:0] w_output;
  logic             load_w;
  logic [WIDTH-1:0] w_data;
  logic             busy;
  logic             done;
  logic             mismatch;

  modport master (
    output start, num_loads, init_w, w_output,
    input  load_w, w_data, busy, done, mismatch
  );

  modport slave (
    input  start, num_loads, init_w, w_output,
    output load_w, w_data, busy, done, mismatch
  );

endinterface

// File: rtl/w_gap_timer.sv
// Loadable down-counter timing the idle interval after each load pulse.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with LOAD_VAL
//   en         : count down by one (saturates at zero)
//   expired_c  : counter is at zero (combinational)
module w_gap_timer #(
  parameter int unsigned W        = 1,
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over count; counting stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(LOAD_VAL);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/w_load_sequencer.sv
// Issues a burst of num_loads load_w strobes (data init_w, init_w+1, ...)
// spaced by GAP idle cycles, then checks that the counter's w_output equals
// the last loaded value and pulses done with the mismatch result.
//   clk   : system clock
//   reset : async active-low reset
//   bus   : command / counter bus (slave side), all outputs registered
module w_load_sequencer
  import w_load_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP   = GAP_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  w_load_sequencer_if.slave     bus
);

  // Timer holds GAP-1 down to 0, i.e. GAP cycles in the GAP state.
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_loads_q, num_loads_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] init_w_q, init_w_d;
  logic [WIDTH-1:0] w_data_q, w_data_d;
  logic             load_w_q, load_w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;

  logic gap_expired_c;
  logic gap_done_c;
  logic last_c;

  w_gap_timer #(
    .W        (GAP_W),
    .LOAD_VAL (GAP - 1)
  ) u_gap_timer (
    .clk       (clk),
    .rst_n     (reset),
    .load      (state_q == S_LOAD),
    .en        (state_q == S_GAP),
    .expired_c (gap_expired_c)
  );

  assign gap_done_c = (state_q == S_GAP) && gap_expired_c;
  // Compare against num_loads-1 so k never has to reach num_loads (15 fits).
  assign last_c     = (k_q == (num_loads_q - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = (bus.num_loads != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD:  state_d = S_GAP;
      S_GAP: begin
        if (gap_done_c) begin
          state_d = last_c ? S_CHECK : S_LOAD;
        end
      end
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; strobes follow the state being entered.
  always_comb begin
    num_loads_d = num_loads_q;
    init_w_d    = init_w_q;
    k_d         = k_q;
    w_data_d    = w_data_q;
    mismatch_d  = mismatch_q;
    load_w_d    = (state_d == S_LOAD);
    busy_d      = (state_d == S_LOAD) || (state_d == S_GAP) || (state_d == S_CHECK);
    done_d      = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_loads_d = bus.num_loads;
          init_w_d    = bus.init_w;
          k_d         = '0;
          mismatch_d  = 1'b0;
          if (bus.num_loads != '0) begin
            w_data_d = bus.init_w;
          end
        end
      end
      S_GAP: begin
        if (gap_done_c && !last_c) begin
          k_d      = k_q + CNT_W'(1);
          w_data_d = init_w_q + WIDTH'(k_d);  // wraps modulo 2^WIDTH
        end
      end
      S_CHECK: mismatch_d = (bus.w_output != w_data_q);
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_loads_q <= '0;
      init_w_q    <= '0;
      k_q         <= '0;
      w_data_q    <= '0;
      load_w_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      num_loads_q <= num_loads_d;
      init_w_q    <= init_w_d;
      k_q         <= k_d;
      w_data_q    <= w_data_d;
      load_w_q    <= load_w_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.load_w   = load_w_q;
  assign bus.w_data   = w_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_w_load_sequencer.sv
// Directed bench for w_load_sequencer (WIDTH=5, CNT_W=4, GAP=2).
module tb_w_load_sequencer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  w_load_sequencer_if #(.WIDTH(5), .CNT_W(4)) bus ();

  w_load_sequencer #(.WIDTH(5), .CNT_W(4), .GAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Rising edges at 7, 17, 27 ... so the reset release at 15 ns is off-edge.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " load_w"},   32'(bus.load_w),   32'd0);
    check({tag, " w_data"},   32'(bus.w_data),   32'd0);
    check({tag, " busy"},     32'(bus.busy),     32'd0);
    check({tag, " done"},     32'(bus.done),     32'd0);
    check({tag, " mismatch"}, 32'(bus.mismatch), 32'd0);
  endtask

  // Start a burst in cycle 0 and check every cycle up to and including done.
  // Pulse k is expected in cycle 1+3k; done in cycle 3n+2 (cycle 1 for n=0).
  // repulse >= 1 re-asserts start (num_loads=9, init_w=0) in that cycle.
  task automatic burst(input string name, input int n, input int init, input int wout,
                       input int repulse, input int exp_mis);
    int done_cyc;
    int n_done;
    bit exp_load;
    int exp_data;
    done_cyc = (n == 0) ? 1 : 3 * n + 2;
    n_done   = 0;
    bus.w_output  = 5'(wout);
    bus.num_loads = 4'(n);
    bus.init_w    = 5'(init);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= done_cyc; c++) begin
      exp_load = 1'b0;
      exp_data = 0;
      for (int k = 0; k < n; k++) begin
        if (c == 1 + 3 * k) begin
          exp_load = 1'b1;
          exp_data = (init + k) % 32;
        end
      end
      check($sformatf("%s c%0d load_w", name, c), 32'(bus.load_w), 32'(exp_load));
      if (exp_load) begin
        check($sformatf("%s c%0d w_data", name, c), 32'(bus.w_data), 32'(exp_data));
      end
      check($sformatf("%s c%0d busy", name, c), 32'(bus.busy), (c < done_cyc) ? 32'd1 : 32'd0);
      if (c == 1) begin
        check($sformatf("%s c1 mismatch cleared", name), 32'(bus.mismatch), 32'd0);
      end
      if (bus.done) n_done++;
      if (c == repulse) begin
        bus.num_loads = 4'd9;
        bus.init_w    = 5'd0;
        bus.start     = 1'b1;
      end
      if (c < done_cyc) begin
        tick();
        bus.start = 1'b0;
      end
    end
    check({name, " done at end"}, 32'(bus.done), 32'd1);
    check({name, " done count"}, 32'(n_done), 32'd1);
    check({name, " mismatch"}, 32'(bus.mismatch), 32'(exp_mis));
    tick();
    check({name, " idle done low"}, 32'(bus.done), 32'd0);
    check({name, " idle busy low"}, 32'(bus.busy), 32'd0);
    check({name, " idle mismatch held"}, 32'(bus.mismatch), 32'(exp_mis));
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.num_loads = '0;
    bus.init_w    = '0;
    bus.w_output  = '0;

    #1;
    check_all_zero("reset");
    #14;
    reset = 1'b1;
    tick();

    burst("basic", 3, 5, 7, -1, 0);

    burst("mism", 3, 5, 3, -1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mism hold %0d", i), 32'(bus.mismatch), 32'd1);
    end

    burst("wrap", 4, 30, 1, -1, 0);

    burst("mism2", 1, 9, 0, -1, 1);
    burst("zero", 0, 17, 0, -1, 0);

    burst("busyprot", 3, 5, 7, 4, 0);

    // Reset in cycle 5 of a 3-load burst: outputs clear without a clock edge.
    bus.w_output  = 5'd7;
    bus.num_loads = 4'd3;
    bus.init_w    = 5'd5;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("abort pre busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("abort hold %0d done", i), 32'(bus.done), 32'd0);
      check($sformatf("abort hold %0d load_w", i), 32'(bus.load_w), 32'd0);
    end
    #2;
    reset = 1'b1;
    tick();
    check("post-reset idle done", 32'(bus.done), 32'd0);
    check("post-reset idle load_w", 32'(bus.load_w), 32'd0);

    burst("fresh", 1, 12, 12, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
